pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised inter-stage pipeline buffer. It is the successor to the fixed F/D latch.
//  It carries a payload word (instr+PC+stage data), an exception code and a branch-delay flag.
//  Transfers use a valid/ready handshake, with 1 or 2 entries of skid buffering and a flush.
//  Used between any two stages (F/D, D/E, E/M, M/W) of the P7 pipeline.
// PARAMETERS
//  DATA_W  64  payload width in bits (e.g. {instr,pc_4})
//  EXC_W   5   exception-code width; 0 = no exception
//  DEPTH   2   entries: 1 = plain register, 2 = skid buffer (registered in_ready)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-low reset
//  flush      in   1       synchronous clear of all entries (bubble insertion)
//  in_valid   in   1       upstream holds a valid entry
//  in_ready   out  1       buffer accepts this cycle
//  in_data    in   DATA_W  payload
//  in_exc     in   EXC_W   exception code
//  in_bd      in   1       entry is in a branch-delay slot
//  out_valid  out  1       head entry valid
//  out_ready  in   1       downstream consumes head this cycle
//  out_data   out  DATA_W  head payload; all-zero (nop) when out_valid=0
//  out_exc    out  EXC_W   head exception code; 0 when out_valid=0
//  out_bd     out  1       head bd flag; 0 when out_valid=0
//  occupancy  out  2       number of valid entries (0..DEPTH)
// BEHAVIOUR
//  - Reset (reset=0, async): all entries invalid; occupancy=0; out_* = 0; in_ready=1.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both are evaluated at the clock edge.
//  - Storage is a FIFO of DEPTH slots with a head pointer (DEPTH=2: 1-bit ptr, wraps 1->0).
//  - Latency: an entry pushed in cycle N is visible at out_* in cycle N+1 (never combinational pass).
//  - in_ready: DEPTH=1 -> (occupancy==0) | out_ready; DEPTH=2 -> occupancy<2 (registered only).
//  - Occupancy transitions:
//      - push & !pop -> +1
//      - pop & !push -> -1
//      - push & pop -> unchanged; the new entry goes to the tail and the head advances.
//  - Full (occupancy=DEPTH) & !pop: in_ready=0, and in_valid is ignored.
//  - Empty: out_valid=0; a pop request is ignored.
//  - flush=1: next cycle occupancy=0 and all slot fields are zeroed.
//      - flush has priority over a simultaneous push and pop; that push is dropped.
//      - The upstream stage treats the flushed cycle as consumed.
//  - Exception/bd fields travel with their payload unchanged; the buffer never merges or reorders entries.
//  - The held head stays stable while out_valid & !out_ready (no payload change).
//  - Reset asserted mid-transfer discards all entries immediately (async).
// CONFIGURATION
//  PIPE_STALL_CNT_EN defined:
//      - adds outputs stall_cnt[31:0] and bubble_cnt[31:0].
//      - stall_cnt increments on cycles with out_valid & !out_ready; bubble_cnt increments on cycles with flush=1.
//      - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
//  Undefined: no counters and no extra ports; the datapath is identical.
// STRUCTURE
//  Shared package pipe_pkg: EXC_W default, EXC_NONE=0, NOP_WORD=32'h0, and the DEPTH legality check (1|2).
//  One sub-module, pipe_slot: a single storage entry {vld,data,exc,bd} with load and clear.
//  It is instantiated DEPTH times; pointer/occupancy control stays in pipe_stage_buf.
// TESTING
//  1. Reset then idle: out_valid=0, out_data=0, occupancy=0, in_ready=1.
//  2. DEPTH=2: push A,B with out_ready=0:
//      - occupancy=2, in_ready=0.
//      - push C is ignored; raise out_ready -> A then B then C in order.
//  3. Full buffer with push&pop in the same cycle:
//      - occupancy stays at DEPTH.
//      - out_data sequence is unbroken (e.g. 0x..10,0x..14,0x..18).
//  4. Exception/bd path: in_exc=5'd10, in_bd=1 pushed -> next cycle out_exc=10, out_bd=1.
//     A flush in the following cycle gives out_exc=0, out_bd=0, out_valid=0.
//  5. flush coincident with push and pop at occupancy=1:
//      - next cycle occupancy=0 and the pushed entry never appears.
//  6. PIPE_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 7 cycles -> stall_cnt=7.
//     Then one flush -> bubble_cnt=1; async reset mid-run clears both.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffers.
package pipe_pkg;

    localparam int unsigned EXC_W_DEF = 5;
    localparam int unsigned EXC_NONE  = 0;
    localparam logic [31:0] NOP_WORD  = 32'h0;

    // Only a plain register (1) or a two-entry skid buffer (2) are supported.
    function automatic bit depth_ok(input int unsigned depth);
        return (depth == 1) || (depth == 2);
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle carrying payload, exception code and branch-delay flag.
interface pipe_stage_buf_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned EXC_W  = 5
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [EXC_W-1:0]  exc;
    logic              bd;

    modport master (output valid, data, exc, bd, input ready);
    modport slave  (input valid, data, exc, bd, output ready);
endinterface

// File: rtl/pipe_slot.sv
// One storage entry {vld, data, exc, bd}; clear wins over load.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned EXC_W  = EXC_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [EXC_W-1:0]  exc_i,
    input  logic              bd_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o,
    output logic [EXC_W-1:0]  exc_o,
    output logic              bd_o
);
    logic              vld_q;
    logic [DATA_W-1:0] data_q;
    logic [EXC_W-1:0]  exc_q;
    logic              bd_q;

    // Entry state: zeroed on reset or clear, captured on load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            exc_q  <= EXC_W'(EXC_NONE);
            bd_q   <= 1'b0;
        end else if (clr_i) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            exc_q  <= EXC_W'(EXC_NONE);
            bd_q   <= 1'b0;
        end else if (load_i) begin
            vld_q  <= 1'b1;
            data_q <= data_i;
            exc_q  <= exc_i;
            bd_q   <= bd_i;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
    assign exc_o  = exc_q;
    assign bd_o   = bd_q;
endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: 1- or 2-entry FIFO with valid/ready handshake and flush.
// Optional build macro PIPE_STALL_CNT_EN adds saturating stall/bubble counters.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned EXC_W  = EXC_W_DEF,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    pipe_stage_buf_if.slave     in_if,
    pipe_stage_buf_if.master    out_if,
    output logic [1:0]          occupancy_o
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt_o,
    output logic [31:0]         bubble_cnt_o
`endif
);
    if (!depth_ok(DEPTH)) begin : g_depth_chk
        $error("pipe_stage_buf: DEPTH must be 1 or 2");
    end

    localparam logic [1:0] Full = 2'(DEPTH);

    logic [1:0]        occ_q, occ_d;
    logic              head_q, head_d;
    logic              tail_ptr;
    logic              in_rdy, push, pop;
    logic [DEPTH-1:0]  head_oh, tail_oh, slot_load, slot_clr, slot_vld, slot_bd;
    logic [DATA_W-1:0] slot_data [DEPTH];
    logic [EXC_W-1:0]  slot_exc  [DEPTH];
    logic              out_vld, out_bd;
    logic [DATA_W-1:0] out_data;
    logic [EXC_W-1:0]  out_exc;

    // Single-entry mode can accept while its head is leaving; skid mode only looks at fill level.
    assign in_rdy = (DEPTH == 1) ? ((occ_q == 2'd0) | out_if.ready) : (occ_q != Full);
    assign push   = in_if.valid & in_rdy;
    assign pop    = out_vld & out_if.ready;

    // Slot selection and per-slot load/clear; flush suppresses any load.
    always_comb begin
        tail_ptr  = (DEPTH == 1) ? 1'b0 : (head_q ^ occ_q[0]);
        head_oh   = '0;
        tail_oh   = '0;
        slot_load = '0;
        slot_clr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            head_oh[i]   = (head_q == 1'(i));
            tail_oh[i]   = (tail_ptr == 1'(i));
            slot_load[i] = push & ~flush_i & tail_oh[i];
            slot_clr[i]  = flush_i | (pop & head_oh[i] & ~slot_load[i]);
        end
    end

    // Next occupancy and head pointer.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        if (flush_i) begin
            occ_d  = 2'd0;
            head_d = 1'b0;
        end else begin
            if (push && !pop) begin
                occ_d = occ_q + 2'd1;
            end else if (pop && !push) begin
                occ_d = occ_q - 2'd1;
            end
            if (pop && DEPTH == 2) begin
                head_d = ~head_q;
            end
        end
    end

    // Pointer/occupancy state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q  <= 2'd0;
            head_q <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        pipe_slot #(
            .DATA_W (DATA_W),
            .EXC_W  (EXC_W)
        ) u_slot (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (slot_clr[g]),
            .load_i (slot_load[g]),
            .data_i (in_if.data),
            .exc_i  (in_if.exc),
            .bd_i   (in_if.bd),
            .vld_o  (slot_vld[g]),
            .data_o (slot_data[g]),
            .exc_o  (slot_exc[g]),
            .bd_o   (slot_bd[g])
        );
    end

    // Head entry select; fields are forced to nop when the head is empty.
    always_comb begin
        out_vld  = 1'b0;
        out_data = '0;
        out_exc  = '0;
        out_bd   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (head_oh[i] && slot_vld[i]) begin
                out_vld  = 1'b1;
                out_data = slot_data[i];
                out_exc  = slot_exc[i];
                out_bd   = slot_bd[i];
            end
        end
    end

    assign in_if.ready  = in_rdy;
    assign out_if.valid = out_vld;
    assign out_if.data  = out_data;
    assign out_if.exc   = out_exc;
    assign out_if.bd    = out_bd;
    assign occupancy_o  = occ_q;

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_q, bubble_q;

    // Saturating counters of held-head cycles and flush cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q  <= 32'd0;
            bubble_q <= 32'd0;
        end else begin
            if (out_vld && !out_if.ready && stall_q != 32'hFFFF_FFFF) begin
                stall_q <= stall_q + 32'd1;
            end
            if (flush_i && bubble_q != 32'hFFFF_FFFF) begin
                bubble_q <= bubble_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o  = stall_q;
    assign bubble_cnt_o = bubble_q;
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf (DEPTH=2) against a queue-based reference model.
module tb_pipe_stage_buf;
    localparam int unsigned DW = 64;
    localparam int unsigned EW = 5;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [EW-1:0] exc;
        logic          bd;
    } ent_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] occupancy;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt, bubble_cnt;
`endif

    pipe_stage_buf_if #(.DATA_W(DW), .EXC_W(EW)) in_if ();
    pipe_stage_buf_if #(.DATA_W(DW), .EXC_W(EW)) out_if ();

    pipe_stage_buf #(
        .DATA_W (DW),
        .EXC_W  (EW),
        .DEPTH  (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_if       (in_if),
        .out_if      (out_if),
        .occupancy_o (occupancy)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt),
        .bubble_cnt_o (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    ent_t        q[$];
    int          checks = 0;
    int          errors = 0;
    longint      m_stall = 0;
    longint      m_bubble = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        ent_t h;
        h = (q.size() != 0) ? q[0] : '0;
        chk({tag, ".out_valid"}, 64'(out_if.valid), 64'(q.size() != 0));
        chk({tag, ".out_data"},  out_if.data,       h.data);
        chk({tag, ".out_exc"},   64'(out_if.exc),   64'(h.exc));
        chk({tag, ".out_bd"},    64'(out_if.bd),    64'(h.bd));
        chk({tag, ".occupancy"}, 64'(occupancy),    64'(q.size()));
        chk({tag, ".in_ready"},  64'(in_if.ready),  64'(q.size() < 2));
`ifdef PIPE_STALL_CNT_EN
        chk({tag, ".stall_cnt"},  64'(stall_cnt),  64'(m_stall));
        chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(m_bubble));
`endif
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic step(input logic fl, input logic iv, input logic [63:0] d,
                        input logic [4:0] e, input logic b, input logic ordy,
                        input string tag);
        bit do_push, do_pop;
        flush        = fl;
        in_if.valid  = iv;
        in_if.data   = d;
        in_if.exc    = e;
        in_if.bd     = b;
        out_if.ready = ordy;
        do_push = iv && (q.size() < 2);
        do_pop  = (q.size() != 0) && ordy;
        if (q.size() != 0 && !ordy && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (fl && m_bubble < 64'hFFFF_FFFF) m_bubble++;
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{data: d, exc: e, bd: b});
        end
        @(posedge clk);
        @(negedge clk);
        check_model(tag);
    endtask

    // Assert reset between edges and check it takes effect without a clock.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        m_stall  = 0;
        m_bubble = 0;
        check_model({tag, ".during"});
        flush        = 1'b0;
        in_if.valid  = 1'b0;
        out_if.ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_model({tag, ".after"});
    endtask

    initial begin
        flush        = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.exc    = '0;
        in_if.bd     = 1'b0;
        out_if.ready = 1'b0;
        repeat (2) @(negedge clk);
        check_model("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_model("idle");

        // Fill with out_ready low, then drain in order.
        step(0, 1, 64'hA, 0, 0, 0, "push_a");
        step(0, 1, 64'hB, 0, 0, 0, "push_b_full");
        step(0, 1, 64'hC, 0, 0, 0, "push_c_ignored");
        step(0, 1, 64'hC, 0, 0, 1, "pop_a");
        step(0, 1, 64'hC, 0, 0, 1, "pop_b_push_c");
        step(0, 0, 64'h0, 0, 0, 1, "pop_c");
        step(0, 0, 64'h0, 0, 0, 1, "empty_pop_ignored");

        // Streaming push and pop in the same cycle.
        step(0, 1, 64'h10, 0, 0, 0, "stream_10");
        step(0, 1, 64'h14, 0, 0, 1, "stream_14");
        step(0, 1, 64'h18, 0, 0, 1, "stream_18");
        step(0, 0, 64'h0,  0, 0, 1, "stream_drain");
        step(0, 0, 64'h0,  0, 0, 1, "stream_empty");

        // Exception and branch-delay fields, then flush.
        step(0, 1, 64'h1234, 5'd10, 1, 0, "exc_push");
        step(1, 0, 64'h0,    5'd0,  0, 0, "exc_flush");

        // Flush coincident with push and pop at occupancy 1.
        step(0, 1, 64'h55, 5'd3, 0, 0, "fpp_fill");
        step(1, 1, 64'h66, 5'd4, 1, 1, "fpp_flush");
        step(0, 0, 64'h0,  5'd0, 0, 1, "fpp_after");

        // Stall and bubble counters from a clean start.
        async_reset("cnt_reset");
        step(0, 1, 64'h77, 0, 0, 0, "cnt_push");
        for (int i = 0; i < 7; i++) step(0, 0, 64'h0, 0, 0, 0, "cnt_hold");
`ifdef PIPE_STALL_CNT_EN
        chk("stall_cnt_7", 64'(stall_cnt), 64'd7);
`endif
        step(1, 0, 64'h0, 0, 0, 0, "cnt_flush");
`ifdef PIPE_STALL_CNT_EN
        chk("bubble_cnt_1", 64'(bubble_cnt), 64'd1);
`endif
        step(0, 1, 64'h88, 0, 0, 0, "cnt_refill");
        async_reset("midrun_reset");
`ifdef PIPE_STALL_CNT_EN
        chk("stall_cnt_cleared", 64'(stall_cnt), 64'd0);
        chk("bubble_cnt_cleared", 64'(bubble_cnt), 64'd0);
`endif

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7), d,
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 6), "rand");
            if (n == 200) async_reset("rand_reset");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
